// File: rtl/jt51_dac_pkg.sv
// jt51_dac_pkg: shared DAC link framing constants, float sample type and word packing
package jt51_dac_pkg;
    localparam int FRAME_SLOTS  = 32;
    localparam int WORD_SLOTS   = 16;
    localparam int MAN_LSB_SLOT = 3;
    localparam int EXP_LSB_SLOT = 13;
    localparam int SH_ON_SLOT   = 8;

    typedef struct packed {
        logic [9:0] man;
        logic [2:0] exp;
    } fp_t;

    function automatic logic [WORD_SLOTS-1:0] make_word(input fp_t f);
        make_word = '0;
        make_word[MAN_LSB_SLOT +: 10] = f.man;
        make_word[EXP_LSB_SLOT +: 3]  = f.exp;
    endfunction
endpackage

// File: rtl/jt51_dac_fpenc.sv
// jt51_dac_fpenc: 16-bit signed linear to 10-bit mantissa / 3-bit exponent float
module jt51_dac_fpenc
    import jt51_dac_pkg::*;
(
    input  logic signed [15:0] x,
    output fp_t                f
);
    // smallest exponent whose shifted value still fits a signed 10-bit mantissa
    always_comb begin
        f.exp = 3'd7;
        for (int e = 6; e >= 1; e--)
            if ((x >>> (e + 8)) == 16'sh0000 || (x >>> (e + 8)) == -16'sh0001) f.exp = 3'(e);
        f.man = 10'(x >>> (f.exp - 3'd1));
    end
endmodule

// File: rtl/jt51_dac_tx.sv
// jt51_dac_tx: float-encodes L/R samples and shifts them onto a YM3012-style SO/SH1/SH2 link
// JT51_DAC_TX_MONO_EN: when defined, both channels carry the (xleft + xright) >>> 1 mix
module jt51_dac_tx
    import jt51_dac_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               smp_stb,
    input  logic signed [15:0] xleft,
    input  logic signed [15:0] xright,
    output logic               so,
    output logic               sh1,
    output logic               sh2,
    output logic               busy
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = $clog2(FRAME_SLOTS);

    fp_t                    enc_l, enc_r;
    logic [DW-1:0]          div;
    logic [SW-1:0]          slot, nslot;
    logic [FRAME_SLOTS-1:0] frame, pend_frame, new_frame;
    logic                   pend, bound, last, sh_on;

`ifdef JT51_DAC_TX_MONO_EN
    logic signed [16:0] sum;
    assign sum = {xleft[15], xleft} + {xright[15], xright};
    jt51_dac_fpenc u_enc_l (.x(16'(sum >>> 1)), .f(enc_l));
    jt51_dac_fpenc u_enc_r (.x(16'(sum >>> 1)), .f(enc_r));
`else
    jt51_dac_fpenc u_enc_l (.x(xleft),  .f(enc_l));
    jt51_dac_fpenc u_enc_r (.x(xright), .f(enc_r));
`endif

    assign new_frame = {make_word(enc_r), make_word(enc_l)};
    assign bound     = div == DW'(DIV - 1);
    assign last      = busy && bound && slot == SW'(FRAME_SLOTS - 1);
    assign nslot     = slot + 1'b1;
    assign sh_on     = nslot[3:0] >= 4'(SH_ON_SLOT);

    // a strobe on the final cen of a frame counts as an idle capture and wins over a pending frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            {so, sh1, sh2, busy, pend} <= '0;
            div        <= '0;
            slot       <= '0;
            frame      <= '0;
            pend_frame <= '0;
        end else if (cen) begin
            if ((smp_stb && (!busy || last)) || (last && pend)) begin
                frame      <= smp_stb ? new_frame : pend_frame;
                so         <= smp_stb ? new_frame[0] : pend_frame[0];
                {sh1, sh2} <= '0;
                busy       <= 1'b1;
                pend       <= 1'b0;
                slot       <= '0;
                div        <= '0;
            end else if (last) begin
                {so, sh1, sh2, busy} <= '0;
                slot <= '0;
                div  <= '0;
            end else if (busy) begin
                div <= bound ? '0 : div + 1'b1;
                if (bound) begin
                    slot  <= nslot;
                    frame <= frame >> 1;
                    so    <= frame[1];
                    sh1   <= sh_on && !nslot[SW-1];
                    sh2   <= sh_on && nslot[SW-1];
                end
                if (smp_stb) begin
                    pend       <= 1'b1;
                    pend_frame <= new_frame;
                end
            end
        end
    end
endmodule
